conv_1x1_weight_streamer: RTL and testbench

- Transmitter end of the 1x1 conv weight interface (`valid_weight_in` / `weight_in` on the 1x1 conv layer).
- Reads one layer's weight set from an on-chip weight memory with 1-cycle read latency.
- Streams the weights one word per cycle, output-channel major, input-channel minor; the conv weight buffer expects exactly this order.
- One `start` pulse streams one full set. `hold` throttles the stream with no loss or reordering.

---
 rtl/conv_1x1_weight_streamer.sv | 116 +++++++++++
 tb/tb_conv_1x1_weight_streamer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_1x1_weight_streamer.sv
// rtl/conv_1x1_weight_streamer.sv - streams one 1x1 conv weight set from a 1-cycle-latency memory
// Output-channel major, input-channel minor; hold throttles read issue without loss.
module conv_1x1_weight_streamer #(
  parameter int DATA_WIDTH      = 32,
  parameter int CHANNEL_NUM_IN  = 2048,
  parameter int CHANNEL_NUM_OUT = 256,
  parameter int ADDR_WIDTH      = 20,
  parameter int BASE_ADDR       = 0,
  parameter int CNT_WIDTH       = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hold,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  valid_weight_out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned          N    = CHANNEL_NUM_IN * CHANNEL_NUM_OUT;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] issue_cnt;
  logic [CNT_WIDTH-1:0] recv_cnt;
  logic                 rd_pending;
  logic                 recv_done;

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [CNT_WIDTH-1:0] cnt);
    return BASE + ADDR_WIDTH'(cnt);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      issue_cnt        <= '0;
      recv_cnt         <= '0;
      rd_pending       <= 1'b0;
      recv_done        <= 1'b0;
      mem_rd_en        <= 1'b0;
      mem_addr         <= '0;
      weight_out       <= '0;
      valid_weight_out <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      rd_pending <= mem_rd_en;

      // recv_cnt may wrap to 0 when N == 2^CNT_WIDTH, so completion is a separate flag
      if (rd_pending) begin
        weight_out       <= mem_data;
        valid_weight_out <= 1'b1;
        recv_cnt         <= recv_cnt + 1'b1;
        recv_done        <= (recv_cnt == LAST);
      end else begin
        valid_weight_out <= 1'b0;
      end

      case (state)
        IDLE: begin
          mem_rd_en <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            busy      <= 1'b1;
            recv_cnt  <= '0;
            recv_done <= 1'b0;
            mem_addr  <= BASE;
            if (!hold) begin
              mem_rd_en <= 1'b1;
              issue_cnt <= CNT_WIDTH'(1);
              state     <= (LAST == '0) ? DRAIN : ISSUE;
            end else begin
              issue_cnt <= '0;
              state     <= ISSUE;
            end
          end
        end

        ISSUE: begin
          // under hold the address parks on the next unread word
          mem_addr  <= addr_of(issue_cnt);
          mem_rd_en <= !hold;
          if (!hold) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == LAST) state <= DRAIN;
          end
        end

        DRAIN: begin
          mem_rd_en <= 1'b0;
          if (recv_done) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        DONE: begin
          mem_rd_en <= 1'b0;
          done      <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_1x1_weight_streamer.sv
// tb/tb_conv_1x1_weight_streamer.sv - directed bench for conv_1x1_weight_streamer
// IN=4, OUT=2, BASE_ADDR=16, memory returns addr+100 one cycle after a read.
module tb_conv_1x1_weight_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        mem_rd_en;
  logic [19:0] mem_addr;
  logic [31:0] mem_data = 32'hDEADBEEF;
  logic [31:0] weight_out;
  logic        valid_weight_out;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] vq[$];
  int          vcyc[$];
  logic [19:0] aq[$];
  int          acyc[$];
  int          dn, dcyc, bcnt, bfirst, blast;

  conv_1x1_weight_streamer #(
    .DATA_WIDTH(32), .CHANNEL_NUM_IN(4), .CHANNEL_NUM_OUT(2),
    .ADDR_WIDTH(20), .BASE_ADDR(16), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .weight_out(weight_out), .valid_weight_out(valid_weight_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_data <= mem_rd_en ? ({12'b0, mem_addr} + 32'd100) : 32'hDEADBEEF;
  end

  always @(negedge clk) begin
    if (valid_weight_out) begin vq.push_back(weight_out); vcyc.push_back(cyc); end
    if (mem_rd_en) begin aq.push_back(mem_addr); acyc.push_back(cyc); end
    if (done) begin dn++; dcyc = cyc; end
    if (busy) begin
      if (bcnt == 0) bfirst = cyc;
      blast = cyc;
      bcnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required < 20000", cyc);
    $fatal(1);
  end

  task automatic clear_logs();
    vq.delete(); vcyc.delete(); aq.delete(); acyc.delete();
    dn = 0; dcyc = -1; bcnt = 0; bfirst = -1; blast = -1;
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic start_pulse(output int t);
    @(posedge clk); #1;
    start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", mem_rd_en); end
    total++; if (mem_addr !== 20'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
    total++; if (weight_out !== 32'd0) begin bad++; $display("FAIL reset_weight got=%0d exp=0", weight_out); end
    total++; if ({valid_weight_out, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {valid_weight_out, busy, done}); end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int t;
    clear_logs();
    start_pulse(t);
    to_cycle(t + 16);
    total++; if (aq.size() !== 8) begin bad++; $display("FAIL basic_reads got=%0d exp=8", aq.size()); end
    for (int i = 0; i < aq.size() && i < 8; i++) begin
      total++;
      if (aq[i] !== 20'(16 + i) || acyc[i] !== t + 1 + i) begin
        bad++; $display("FAIL basic_addr[%0d] got=%0d@%0d exp=%0d@%0d", i, aq[i], acyc[i], 16 + i, t + 1 + i);
      end
    end
    total++; if (vq.size() !== 8) begin bad++; $display("FAIL basic_words got=%0d exp=8", vq.size()); end
    for (int i = 0; i < vq.size() && i < 8; i++) begin
      total++;
      if (vq[i] !== 32'(116 + i) || vcyc[i] !== t + 3 + i) begin
        bad++; $display("FAIL basic_word[%0d] got=%0d@%0d exp=%0d@%0d", i, vq[i], vcyc[i], 116 + i, t + 3 + i);
      end
    end
    total++; if (dn !== 1 || dcyc !== t + 11) begin bad++; $display("FAIL basic_done got=%0d@%0d exp=1@%0d", dn, dcyc, t + 11); end
    total++;
    if (bcnt !== 10 || bfirst !== t + 1 || blast !== t + 10) begin
      bad++; $display("FAIL basic_busy got=%0d[%0d..%0d] exp=10[%0d..%0d]", bcnt, bfirst, blast, t + 1, t + 10);
    end
  endtask

  task automatic test_hold_mid();
    int t;
    clear_logs();
    start_pulse(t);
    to_cycle(t + 3);
    hold = 1'b1;
    for (int k = 4; k <= 6; k++) begin
      to_cycle(t + k);
      total++;
      if (mem_rd_en !== 1'b0 || mem_addr !== 20'd19) begin
        bad++; $display("FAIL hold_frozen@T+%0d got=rd%b/%0d exp=rd0/19", k, mem_rd_en, mem_addr);
      end
      if (k == 6) hold = 1'b0;
    end
    to_cycle(t + 20);
    total++; if (aq.size() !== 8) begin bad++; $display("FAIL hold_reads got=%0d exp=8", aq.size()); end
    for (int i = 0; i < aq.size() && i < 8; i++) begin
      total++;
      if (aq[i] !== 20'(16 + i) || acyc[i] !== t + 1 + i + ((i >= 3) ? 3 : 0)) begin
        bad++; $display("FAIL hold_addr[%0d] got=%0d@%0d exp=%0d@%0d", i, aq[i], acyc[i], 16 + i, t + 1 + i + ((i >= 3) ? 3 : 0));
      end
    end
    total++; if (vq.size() !== 8) begin bad++; $display("FAIL hold_words got=%0d exp=8", vq.size()); end
    for (int i = 0; i < vq.size() && i < 8; i++) begin
      total++;
      if (vq[i] !== 32'(116 + i) || vcyc[i] !== t + 3 + i + ((i >= 3) ? 3 : 0)) begin
        bad++; $display("FAIL hold_word[%0d] got=%0d@%0d exp=%0d@%0d", i, vq[i], vcyc[i], 116 + i, t + 3 + i + ((i >= 3) ? 3 : 0));
      end
    end
    total++; if (dn !== 1 || dcyc !== t + 14) begin bad++; $display("FAIL hold_done got=%0d@%0d exp=1@%0d", dn, dcyc, t + 14); end
  endtask

  task automatic test_start_while_busy();
    int t;
    clear_logs();
    start_pulse(t);
    to_cycle(t + 5);
    start = 1'b1;
    to_cycle(t + 6);
    start = 1'b0;
    to_cycle(t + 22);
    total++; if (aq.size() !== 8) begin bad++; $display("FAIL busy_start_reads got=%0d exp=8", aq.size()); end
    total++; if (vq.size() !== 8) begin bad++; $display("FAIL busy_start_words got=%0d exp=8", vq.size()); end
    total++; if (dn !== 1) begin bad++; $display("FAIL busy_start_done got=%0d exp=1", dn); end
  endtask

  task automatic test_reset_mid();
    int t;
    clear_logs();
    start_pulse(t);
    to_cycle(t + 6);
    reset = 1'b1;
    to_cycle(t + 7);
    total++;
    if ({mem_rd_en, valid_weight_out, busy, done} !== 4'b0000 || mem_addr !== 20'd0 || weight_out !== 32'd0) begin
      bad++; $display("FAIL midreset_outputs got=rd%b v%b b%b d%b a%0d w%0d exp=all 0",
                      mem_rd_en, valid_weight_out, busy, done, mem_addr, weight_out);
    end
    reset = 1'b0;
    to_cycle(t + 20);
    total++; if (dn !== 0) begin bad++; $display("FAIL midreset_no_done got=%0d exp=0", dn); end
    clear_logs();
    start_pulse(t);
    to_cycle(t + 16);
    total++; if (vq.size() !== 8) begin bad++; $display("FAIL midreset_words got=%0d exp=8", vq.size()); end
    for (int i = 0; i < vq.size() && i < 8; i++) begin
      total++;
      if (vq[i] !== 32'(116 + i)) begin bad++; $display("FAIL midreset_word[%0d] got=%0d exp=%0d", i, vq[i], 116 + i); end
    end
    total++; if (dn !== 1) begin bad++; $display("FAIL midreset_done got=%0d exp=1", dn); end
  endtask

  task automatic test_back_to_back();
    int t;
    clear_logs();
    start_pulse(t);
    // start held through the done cycle: ignored at T+11, accepted at T+12
    to_cycle(t + 11);
    start = 1'b1;
    to_cycle(t + 13);
    start = 1'b0;
    to_cycle(t + 30);
    total++; if (aq.size() !== 16) begin bad++; $display("FAIL b2b_reads got=%0d exp=16", aq.size()); end
    if (aq.size() >= 9) begin
      total++;
      if (aq[8] !== 20'd16 || acyc[8] !== t + 13) begin
        bad++; $display("FAIL b2b_restart got=%0d@%0d exp=16@%0d", aq[8], acyc[8], t + 13);
      end
    end
    total++; if (vq.size() !== 16) begin bad++; $display("FAIL b2b_words got=%0d exp=16", vq.size()); end
    for (int i = 0; i < vq.size() && i < 16; i++) begin
      total++;
      if (vq[i] !== 32'(116 + (i % 8))) begin bad++; $display("FAIL b2b_word[%0d] got=%0d exp=%0d", i, vq[i], 116 + (i % 8)); end
    end
    total++; if (dn !== 2 || dcyc !== t + 23) begin bad++; $display("FAIL b2b_done got=%0d@%0d exp=2@%0d", dn, dcyc, t + 23); end
  endtask

  task automatic test_hold_before_start();
    int t, h;
    clear_logs();
    hold = 1'b1;
    start_pulse(t);
    to_cycle(t + 5);
    total++; if (aq.size() !== 0) begin bad++; $display("FAIL prehold_reads got=%0d exp=0", aq.size()); end
    total++; if (vq.size() !== 0) begin bad++; $display("FAIL prehold_words got=%0d exp=0", vq.size()); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL prehold_busy got=%b exp=1", busy); end
    hold = 1'b0;
    h = cyc;
    to_cycle(h + 16);
    total++; if (vq.size() !== 8) begin bad++; $display("FAIL prehold_words_after got=%0d exp=8", vq.size()); end
    if (vq.size() > 0) begin
      total++;
      if (vcyc[0] !== h + 3 || vq[0] !== 32'd116) begin
        bad++; $display("FAIL prehold_first got=%0d@%0d exp=116@%0d", vq[0], vcyc[0], h + 3);
      end
    end
    if (vq.size() == 8) begin
      total++;
      if (vq[7] !== 32'd123) begin bad++; $display("FAIL prehold_last got=%0d exp=123", vq[7]); end
    end
    total++; if (dn !== 1) begin bad++; $display("FAIL prehold_done got=%0d exp=1", dn); end
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_basic();
    test_hold_mid();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_hold_before_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
